// File: rtl/wb_cmd_master.sv
// Purpose : single-transfer Wishbone initiator that turns valid/ready commands into classic STB/ACK cycles.
// Latency : command edge N -> STB high from N; response valid one edge after ACK (zero-wait slave: after N+1).
// Backpr. : one command in flight; oCMD_RDY only in IDLE, response held stable until iRSP_RDY.
//
// Ports
//   iCLK, iRST                 clock, synchronous active-high reset
//   iCMD_VALID/oCMD_RDY        command handshake; iCMD_WE/iCMD_ADR/iCMD_DAT sampled on accept edge only
//   oRSP_VALID/iRSP_RDY        response handshake; oRSP_DAT (read data, else 0), oRSP_ERR (timeout abort)
//   oADR/oDAT/oWE/oSTB         Wishbone initiator outputs, all registered
//   iDAT/iACK                  Wishbone slave returns; ignored outside a bus cycle
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCMD_VALID,
    output logic          oCMD_RDY,
    input  logic          iCMD_WE,
    input  logic [AW-1:0] iCMD_ADR,
    input  logic [DW-1:0] iCMD_DAT,
    output logic          oRSP_VALID,
    input  logic          iRSP_RDY,
    output logic [DW-1:0] oRSP_DAT,
    output logic          oRSP_ERR,
    output logic [AW-1:0] oADR,
    output logic [DW-1:0] oDAT,
    input  logic [DW-1:0] iDAT,
    output logic          oWE,
    output logic          oSTB,
    input  logic          iACK
);

    // One extra bit so TIMEOUT-1 is always representable; the count stops there.
    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmd_rdy_q, cmd_rdy_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          rsp_vld_q, rsp_vld_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    logic          timeout_hit;
    assign timeout_hit = (cnt_q == CNT_LAST);

    // State and output registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_rdy_q <= 1'b1;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_rdy_q <= cmd_rdy_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (iCMD_VALID)              state_d = ST_BUS;
            ST_BUS:  if (iACK || timeout_hit)     state_d = ST_RESP;
            ST_RESP: if (iRSP_RDY)                state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Output next-values; everything holds unless the current state changes it.
    always_comb begin
        cnt_d     = cnt_q;
        cmd_rdy_d = cmd_rdy_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iCMD_VALID) begin
                    we_d      = iCMD_WE;
                    adr_d     = iCMD_ADR;
                    dat_d     = iCMD_DAT;
                    stb_d     = 1'b1;
                    cmd_rdy_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_BUS: begin
                // ACK is checked first so an ACK on the last allowed cycle completes normally.
                if (iACK) begin
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    rsp_dat_d = we_q ? '0 : iDAT;
                    rsp_err_d = 1'b0;
                    rsp_vld_d = 1'b1;
                end else if (timeout_hit) begin
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (iRSP_RDY) begin
                    rsp_vld_d = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                    cmd_rdy_d = 1'b1;
                end
            end
            default: begin
                cmd_rdy_d = 1'b1;
                stb_d     = 1'b0;
                rsp_vld_d = 1'b0;
            end
        endcase
    end

    assign oCMD_RDY   = cmd_rdy_q;
    assign oSTB       = stb_q;
    assign oWE        = we_q;
    assign oADR       = adr_q;
    assign oDAT       = dat_q;
    assign oRSP_VALID = rsp_vld_q;
    assign oRSP_DAT   = rsp_dat_q;
    assign oRSP_ERR   = rsp_err_q;

endmodule
